// File: rtl/noc_input_fifo_rx.sv
// rtl/noc_input_fifo_rx.sv - router input port FIFO receiving flits over the RTS/CTS link
module noc_input_fifo_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DRTS,
  input  logic [DATA_WIDTH-1:0] RX,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  cts_ff;
  logic                  write_en;
  logic                  read_any;
  logic                  read_valid;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign Data_out = mem[rd_ptr];
  assign CTS      = cts_ff;

  // cts_ff blocks a second write while the upstream still holds RTS during its grant cycle
  assign write_en   = DRTS & ~cts_ff & ~full;
  assign read_any   = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
  assign read_valid = read_any & ~empty;

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr] <= RX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cts_ff <= 1'b0;
    end else begin
      cts_ff <= write_en;
      if (write_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (read_valid) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({write_en, read_valid})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_input_fifo_rx.sv
// tb/tb_noc_input_fifo_rx.sv - self-checking bench for noc_input_fifo_rx
module tb_noc_input_fifo_rx;

  logic        clk;
  logic        rst;
  logic        DRTS;
  logic [31:0] RX;
  logic        CTS;
  logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [31:0] Data_out;
  logic        empty;
  logic        full;

  int checks;
  int failures;

  typedef struct {
    logic        drts;
    logic [31:0] rx;
    logic [4:0]  rd;   // {N,E,W,S,L}
    logic        e_cts;
    logic        e_empty;
    logic        e_full;
    logic        chk_data;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  localparam logic [4:0] RN = 5'b10000;
  localparam logic [4:0] RE = 5'b01000;
  localparam logic [4:0] RW = 5'b00100;
  localparam logic [4:0] RS = 5'b00010;
  localparam logic [4:0] RL = 5'b00001;

  noc_input_fifo_rx #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .DRTS(DRTS), .RX(RX), .CTS(CTS),
    .read_en_N(read_en_N), .read_en_E(read_en_E), .read_en_W(read_en_W),
    .read_en_S(read_en_S), .read_en_L(read_en_L),
    .Data_out(Data_out), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic drts, input logic [31:0] rx, input logic [4:0] rd,
                     input logic cts, input logic emp, input logic ful,
                     input logic chk, input logic [31:0] dout);
    vec_t v;
    v.drts = drts; v.rx = rx; v.rd = rd;
    v.e_cts = cts; v.e_empty = emp; v.e_full = ful;
    v.chk_data = chk; v.e_dout = dout;
    vecs.push_back(v);
  endtask

  task automatic set_rd(input logic [4:0] rd);
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    DRTS = 1'b1; RX = d;
    step();
    check("hs_cts_high", 32'(CTS), 32'd1);
    DRTS = 1'b0;
    step();
    check("hs_cts_low", 32'(CTS), 32'd0);
  endtask

  task automatic pop(input logic [31:0] exp);
    check("pop_not_empty", 32'(empty), 32'd0);
    check("pop_head", Data_out, exp);
    set_rd(RE);
    step();
    set_rd(5'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    DRTS = 1'b0;
    RX = '0;
    set_rd(5'b0);

    // directed vector table: single flit, empty pops, fill/full stall, multi-grant pops, read+write
    add(1, 32'hA5A5_0001, 0,       1, 0, 0, 1, 32'hA5A5_0001);
    add(1, 32'hA5A5_0001, 0,       0, 0, 0, 1, 32'hA5A5_0001);
    add(0, 0,             RE,      0, 1, 0, 0, 0);
    add(0, 0,             RN | RS, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      add(1, 32'(k), 0, 1, 0, (k == 4), 1, 32'h1);
      add(1, 32'(k), 0, 0, 0, (k == 4), 1, 32'h1);
    end
    for (int k = 0; k < 6; k++) add(1, 32'h5, 0, 0, 0, 1, 1, 32'h1);
    add(1, 32'h5,  RL,      0, 0, 0, 1, 32'h2);
    add(1, 32'h5,  0,       1, 0, 1, 1, 32'h2);
    add(0, 0,      0,       0, 0, 1, 1, 32'h2);
    add(0, 0,      RW | RS, 0, 0, 0, 1, 32'h3);
    add(0, 0,      RN | RE, 0, 0, 0, 1, 32'h4);
    add(1, 32'h66, RN,      1, 0, 0, 1, 32'h5);
    add(0, 0,      0,       0, 0, 0, 1, 32'h5);
    add(0, 0,      RW,      0, 0, 0, 1, 32'h66);
    add(0, 0,      RS,      0, 1, 0, 0, 0);

    step();
    step();
    check("reset_cts", 32'(CTS), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) step();
    check("idle_cts", 32'(CTS), 32'd0);
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_full", 32'(full), 32'd0);

    foreach (vecs[i]) begin
      DRTS = vecs[i].drts;
      RX   = vecs[i].rx;
      set_rd(vecs[i].rd);
      step();
      check($sformatf("vec%0d_cts", i), 32'(CTS), 32'(vecs[i].e_cts));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_dout", i), Data_out, vecs[i].e_dout);
    end
    DRTS = 1'b0;
    set_rd(5'b0);

    // wrap-around: pointers cycle several times, order must be preserved
    for (int i = 0; i < 10; i += 2) begin
      send(32'h10 + 32'(i));
      send(32'h11 + 32'(i));
      pop(32'h10 + 32'(i));
      pop(32'h11 + 32'(i));
    end
    check("wrap_empty", 32'(empty), 32'd1);

    // asynchronous reset while CTS is high drops the just-written flit
    DRTS = 1'b1; RX = 32'hDEAD_BEEF;
    step();
    check("rst_pre_cts", 32'(CTS), 32'd1);
    check("rst_pre_empty", 32'(empty), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_cts", 32'(CTS), 32'd0);
    check("rst_async_empty", 32'(empty), 32'd1);
    check("rst_async_full", 32'(full), 32'd0);
    DRTS = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("rst_post_empty", 32'(empty), 32'd1);
    check("rst_post_cts", 32'(CTS), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
